pipelined_memory: RTL and testbench

- Parametrised successor to the flat main memory: word-addressed RAM with valid/ready request handshake, byte-lane write strobes and a configurable registered read latency.
- Out-of-range addresses produce an error response.
- Sits between the CPU/bus fabric and storage; every accepted request yields exactly one in-order response.

---
 rtl/mem_pkg.sv | 19 +
 rtl/pipelined_memory_resp_pipe.sv | 54 +++++
 rtl/pipelined_memory.sv | 155 +++++++++++++++
 tb/tb_pipelined_memory.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for pipelined_memory: response record, lane count and clear FSM states.
package mem_pkg;

    localparam int MEM_WORD_SIZE = 32;
    localparam int MEM_LANE_SIZE = 8;
    localparam int LANES         = MEM_WORD_SIZE / MEM_LANE_SIZE;

    typedef struct packed {
        logic                     valid;
        logic                     error;
        logic [MEM_WORD_SIZE-1:0] data;
    } resp_t;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/pipelined_memory_resp_pipe.sv
// resp_pipe: depth-N delay line carrying {valid, error, data} response records in order.
module resp_pipe #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    input  logic             i_error,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic             o_error,
    output logic [WIDTH-1:0] o_data,
    output logic             o_busy
);

    localparam int EW = WIDTH + 2;

    logic [DEPTH-1:0][EW-1:0] r_stage;
    logic [EW-1:0]            w_entry;
    logic [DEPTH-1:0]         w_valid_bits;

    assign w_entry = {i_valid, i_error, i_data};

    if (DEPTH == 1) begin : g_single
        // Single stage: the entry is captured directly into the output register
        always_ff @(posedge clk) begin
            if (reset) begin
                r_stage <= '0;
            end else begin
                r_stage[0] <= w_entry;
            end
        end
    end else begin : g_multi
        // Shift one stage per cycle; stage 0 takes the new entry
        always_ff @(posedge clk) begin
            if (reset) begin
                r_stage <= '0;
            end else begin
                r_stage <= {r_stage[DEPTH-2:0], w_entry};
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_valid
        assign w_valid_bits[g] = r_stage[g][EW-1];
    end

    assign o_valid = r_stage[DEPTH-1][EW-1];
    assign o_error = r_stage[DEPTH-1][EW-2];
    assign o_data  = r_stage[DEPTH-1][WIDTH-1:0];
    assign o_busy  = |w_valid_bits;

endmodule

// File: rtl/pipelined_memory.sv
// Word-addressed RAM with valid/ready requests, lane strobes and a fixed in-order response latency.
// Optional power-up zero sweep is enabled by defining PIPELINED_MEMORY_CLEAR_EN.
module pipelined_memory
    import mem_pkg::*;
#(
    parameter int WORD_SIZE    = 32,
    parameter int LANE_SIZE    = 8,
    parameter int LEN          = 65536,
    parameter int LEN_LOG_2    = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_write,
    input  logic [LEN_LOG_2-1:0]           req_addr,
    input  logic [WORD_SIZE-1:0]           req_data,
    input  logic [WORD_SIZE/LANE_SIZE-1:0] req_strobe,
    output logic                           resp_valid,
    output logic [WORD_SIZE-1:0]           resp_data,
    output logic                           resp_error,
    output logic                           busy
);

    localparam int          N_LANES = WORD_SIZE / LANE_SIZE;
    localparam int          IDX_W   = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [31:0] LEN_U   = LEN;

    if ((WORD_SIZE % LANE_SIZE) != 0 || READ_LATENCY < 1 || READ_LATENCY > 8 ||
        (64'd1 << LEN_LOG_2) < 64'(LEN) || IDX_W > LEN_LOG_2) begin : g_bad_params
        $error("pipelined_memory: illegal parameter combination");
    end

    logic [WORD_SIZE-1:0] r_mem [LEN];

    logic                 w_accept;
    logic                 w_in_range;
    logic                 w_wr_en;
    logic [IDX_W-1:0]     w_idx;
    logic [WORD_SIZE-1:0] w_rd_word;
    logic                 w_clearing;
    logic                 w_clr_we;
    logic [IDX_W-1:0]     w_clr_idx;
    logic                 w_pipe_busy;

    logic                 r_req_valid;
    logic                 r_req_error;
    logic [WORD_SIZE-1:0] r_req_data;

    assign w_idx      = req_addr[IDX_W-1:0];
    assign w_in_range = (32'(req_addr) < LEN_U);
    assign req_ready  = !reset && !w_clearing;
    assign w_accept   = req_valid && req_ready;
    assign w_wr_en    = w_accept && w_in_range && req_write;
    assign w_rd_word  = r_mem[w_idx];

`ifdef PIPELINED_MEMORY_CLEAR_EN
    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_clr_cnt;
    logic [IDX_W-1:0] w_clr_cnt_nxt;

    // Clear FSM state and sweep address; any reset restarts the sweep at word 0
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // Next-state logic: one zero write per cycle until the last word is cleared
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_clr_we      = 1'b0;
        case (r_state)
            CLEAR: begin
                w_clr_we = !reset;
                if (r_clr_cnt == IDX_W'(LEN - 1)) begin
                    w_state_nxt   = RUN;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + IDX_W'(1);
                end
            end
            RUN: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt   = RUN;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    assign w_clr_idx  = r_clr_cnt;
    assign w_clearing = (r_state == CLEAR);
`else
    assign w_clr_we   = 1'b0;
    assign w_clr_idx  = '0;
    assign w_clearing = 1'b0;
`endif

    // Array write port: the clear sweep and request writes never coincide (req_ready is low while clearing)
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_idx] <= '0;
        end else if (w_wr_en) begin
            for (int i = 0; i < N_LANES; i++) begin
                if (req_strobe[i]) begin
                    r_mem[w_idx][i*LANE_SIZE +: LANE_SIZE] <= req_data[i*LANE_SIZE +: LANE_SIZE];
                end
            end
        end
    end

    // Accept stage: the array is sampled on the accept edge, so it sees only earlier writes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_valid <= 1'b0;
            r_req_error <= 1'b0;
            r_req_data  <= '0;
        end else begin
            r_req_valid <= w_accept;
            r_req_error <= w_accept && !w_in_range;
            if (w_accept && w_in_range && !req_write) begin
                r_req_data <= w_rd_word;
            end else begin
                r_req_data <= '0;
            end
        end
    end

    resp_pipe #(
        .DEPTH (READ_LATENCY),
        .WIDTH (WORD_SIZE)
    ) u_resp_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_valid (r_req_valid),
        .i_error (r_req_error),
        .i_data  (r_req_data),
        .o_valid (resp_valid),
        .o_error (resp_error),
        .o_data  (resp_data),
        .o_busy  (w_pipe_busy)
    );

    assign busy = !reset && (w_clearing || r_req_valid || w_pipe_busy);

endmodule

// File: tb/tb_pipelined_memory.sv
// Self-checking bench for pipelined_memory: directed scenarios plus randomized traffic vs a word-level model.
module tb_pipelined_memory;
    import mem_pkg::*;

`ifdef PIPELINED_MEMORY_CLEAR_EN
    localparam int TB_LEN = 16;
    localparam int EXP_NOT_READY = 16;
`else
    localparam int TB_LEN = 1000;
    localparam int EXP_NOT_READY = 0;
`endif
    localparam int          LAT     = 2;
    localparam logic [15:0] A_BASIC = (TB_LEN > 16) ? 16'h0010 : 16'h0003;
    localparam logic [15:0] A_STRB  = (TB_LEN > 32) ? 16'h0020 : 16'h0007;
    localparam logic [15:0] A_OOR   = 16'(TB_LEN);
    localparam logic [15:0] A_LAST  = 16'(TB_LEN - 1);

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_strobe;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_error;
    logic        busy;

    pipelined_memory #(
        .WORD_SIZE    (32),
        .LANE_SIZE    (8),
        .LEN          (TB_LEN),
        .LEN_LOG_2    (16),
        .READ_LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_strobe (req_strobe),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_error (resp_error),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int    due;
        resp_t r;
    } exp_t;

    logic [31:0] mdl_mem [int];
    exp_t        exp_q [$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic        exp_valid;
    logic        exp_error;
    logic [31:0] exp_data;

    task automatic set_req(input logic v, input logic w, input logic [15:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        req_valid  = v;
        req_write  = w;
        req_addr   = a;
        req_data   = d;
        req_strobe = s;
    endtask

    // Advance one clock: update the model on accept, then expose this cycle's expected response
    task automatic tick();
        exp_t        e;
        logic        acc;
        logic        rst_at_edge;
        logic [31:0] word;
        int          a;
        #1;
        acc         = (req_valid === 1'b1) && (req_ready === 1'b1);
        rst_at_edge = reset;
        a           = int'(req_addr);
        if (acc) begin
            e.due     = cyc + 1 + LAT;
            e.r.valid = 1'b1;
            e.r.error = (a >= TB_LEN);
            e.r.data  = 32'h0;
            if (a < TB_LEN) begin
                if (req_write) begin
                    word = mdl_mem.exists(a) ? mdl_mem[a] : 'x;
                    for (int i = 0; i < LANES; i++)
                        if (req_strobe[i]) word[i*MEM_LANE_SIZE +: MEM_LANE_SIZE] = req_data[i*MEM_LANE_SIZE +: MEM_LANE_SIZE];
                    mdl_mem[a] = word;
                end else begin
                    e.r.data = mdl_mem.exists(a) ? mdl_mem[a] : 'x;
                end
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        if (rst_at_edge) begin
            exp_q.delete();
`ifdef PIPELINED_MEMORY_CLEAR_EN
            for (int i = 0; i < TB_LEN; i++) mdl_mem[i] = 32'h0;
`endif
        end
        @(negedge clk);
        exp_valid = 1'b0;
        exp_error = 1'b0;
        exp_data  = 32'h0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e         = exp_q.pop_front();
            exp_valid = 1'b1;
            exp_error = e.r.error;
            exp_data  = e.r.data;
        end
    endtask

    // Pulse reset, release it and wait (bounded) for req_ready
    task automatic do_reset(input int hold, output int not_ready, output int busy_gaps, output int pulses);
        set_req(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        reset = 1'b1;
        repeat (hold) tick();
        reset     = 1'b0;
        not_ready = 0;
        busy_gaps = 0;
        pulses    = 0;
        for (int i = 0; i < 2 * TB_LEN + 20; i++) begin
            #1;
            if (req_ready === 1'b1) break;
            not_ready++;
            if (busy !== 1'b1) busy_gaps++;
            tick();
            if (resp_valid !== 1'b0) pulses++;
        end
    endtask

    task automatic test_reset();
        int nr, gaps, pulses;
        reset = 1'b1;
        set_req(1'b1, 1'b1, 16'h0005, 32'hCAFEF00D, 4'hF);
        tick();
        n_chk++;
        if ({resp_valid, resp_error, resp_data, busy, req_ready} !== 35'h0)
            $display("FAIL reset_outputs got v=%b e=%b d=%h busy=%b ready=%b want all 0",
                     resp_valid, resp_error, resp_data, busy, req_ready);
        else n_pass++;
        do_reset(1, nr, gaps, pulses);
        n_chk++;
        if (nr !== EXP_NOT_READY) $display("FAIL reset_ready_delay got %0d want %0d", nr, EXP_NOT_READY);
        else n_pass++;
        n_chk++;
        if (gaps !== 0) $display("FAIL reset_busy_while_clearing got %0d idle cycles want 0", gaps);
        else n_pass++;
    endtask

    task automatic test_basic_rw();
        int          nresp = 0;
        int          rd_edge = 0;
        logic [31:0] got_d [2];
        logic        got_e [2];
        int          got_c [2];
        for (int i = 0; i < LAT + 6; i++) begin
            case (i)
                0:       set_req(1'b1, 1'b1, A_BASIC, 32'hDEADBEEF, 4'hF);
                1:       set_req(1'b1, 1'b0, A_BASIC, 32'h0, 4'h0);
                default: set_req(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
            endcase
            tick();
            if (i == 1) rd_edge = cyc;
            n_chk++;
            if ({resp_valid, resp_error, resp_data} !== {exp_valid, exp_error, exp_data})
                $display("FAIL basic_rw cyc=%0d got v=%b e=%b d=%h want v=%b e=%b d=%h",
                         cyc, resp_valid, resp_error, resp_data, exp_valid, exp_error, exp_data);
            else n_pass++;
            if (resp_valid === 1'b1 && nresp < 2) begin
                got_d[nresp] = resp_data; got_e[nresp] = resp_error; got_c[nresp] = cyc; nresp++;
            end
        end
        n_chk++;
        if (nresp != 2) $display("FAIL basic_resp_count got %0d want 2", nresp);
        else if ({got_e[0], got_d[0]} !== 33'h0) $display("FAIL basic_write_resp got e=%b d=%h want e=0 d=0", got_e[0], got_d[0]);
        else if (got_d[1] !== 32'hDEADBEEF) $display("FAIL basic_read_data got %h want deadbeef", got_d[1]);
        else if (got_c[1] != rd_edge + LAT) $display("FAIL basic_read_latency got %0d want %0d", got_c[1] - rd_edge, LAT);
        else n_pass++;
    endtask

    task automatic test_strobe();
        int          nresp = 0;
        logic [31:0] rd = 32'h0;
        for (int i = 0; i < LAT + 7; i++) begin
            case (i)
                0:       set_req(1'b1, 1'b1, A_STRB, 32'h11223344, 4'hF);
                1:       set_req(1'b1, 1'b1, A_STRB, 32'hAABBCCDD, 4'h5);
                2:       set_req(1'b1, 1'b0, A_STRB, 32'h0, 4'h0);
                default: set_req(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
            endcase
            tick();
            n_chk++;
            if ({resp_valid, resp_error, resp_data} !== {exp_valid, exp_error, exp_data})
                $display("FAIL strobe cyc=%0d got v=%b e=%b d=%h want v=%b e=%b d=%h",
                         cyc, resp_valid, resp_error, resp_data, exp_valid, exp_error, exp_data);
            else n_pass++;
            if (resp_valid === 1'b1) begin
                nresp++;
                if (nresp == 3) rd = resp_data;
            end
        end
        n_chk++;
        if (nresp != 3 || rd !== 32'h11BB33DD) $display("FAIL strobe_merge got n=%0d d=%h want n=3 d=11bb33dd", nresp, rd);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int   nresp = 0, first_c = -1, last_c = -1;
        logic busy_last = 1'b0, busy_after = 1'b1;
        for (int i = 0; i < 8 + LAT + 3; i++) begin
            if (i < 8) set_req(1'b1, 1'b1, 16'(i), $urandom, 4'hF);
            else       set_req(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
            tick();
            n_chk++;
            if ({resp_valid, resp_error, resp_data} !== {exp_valid, exp_error, exp_data})
                $display("FAIL b2b_fill cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, resp_valid, resp_data, exp_valid, exp_data);
            else n_pass++;
        end
        for (int i = 0; i < 8 + LAT + 4; i++) begin
            if (i < 8) set_req(1'b1, 1'b0, 16'(i), 32'h0, 4'h0);
            else       set_req(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
            tick();
            n_chk++;
            if ({resp_valid, resp_error, resp_data} !== {exp_valid, exp_error, exp_data})
                $display("FAIL b2b_read cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, resp_valid, resp_data, exp_valid, exp_data);
            else n_pass++;
            if (last_c >= 0 && cyc == last_c + 1) busy_after = busy;
            if (resp_valid === 1'b1) begin
                if (first_c < 0) first_c = cyc;
                last_c = cyc; busy_last = busy; nresp++;
            end
        end
        n_chk++;
        if (nresp != 8 || last_c - first_c != 7) $display("FAIL b2b_pulses got n=%0d span=%0d want n=8 span=7", nresp, last_c - first_c);
        else n_pass++;
        n_chk++;
        if (busy_last !== 1'b1 || busy_after !== 1'b0) $display("FAIL b2b_busy_fall got last=%b after=%b want 1 then 0", busy_last, busy_after);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        int          nresp = 0, nerr = 0;
        logic [31:0] last_rd = 32'h0;
        for (int i = 0; i < LAT + 8; i++) begin
            case (i)
                0:       set_req(1'b1, 1'b1, A_LAST, 32'h12345678, 4'hF);
                1:       set_req(1'b1, 1'b1, A_OOR, 32'h00000055, 4'hF);
                2:       set_req(1'b1, 1'b0, A_OOR, 32'h0, 4'h0);
                3:       set_req(1'b1, 1'b0, A_LAST, 32'h0, 4'h0);
                default: set_req(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
            endcase
            tick();
            n_chk++;
            if ({resp_valid, resp_error, resp_data} !== {exp_valid, exp_error, exp_data})
                $display("FAIL oor cyc=%0d got v=%b e=%b d=%h want v=%b e=%b d=%h",
                         cyc, resp_valid, resp_error, resp_data, exp_valid, exp_error, exp_data);
            else n_pass++;
            if (resp_valid === 1'b1) begin
                nresp++;
                if (resp_error === 1'b1 && resp_data === 32'h0) nerr++;
                if (nresp == 4) last_rd = resp_data;
            end
        end
        n_chk++;
        if (nerr != 2 || last_rd !== 32'h12345678) $display("FAIL oor_summary got errs=%0d last=%h want errs=2 last=12345678", nerr, last_rd);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [15:0] a;
        for (int i = 0; i < 16 + 400 + LAT + 3; i++) begin
            if (i < 16) begin
                set_req(1'b1, 1'b1, 16'(i), $urandom, 4'hF);
            end else if (i < 416) begin
                if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'(TB_LEN + $urandom_range(0, 3));
                else a = 16'($urandom_range(0, 15));
                set_req(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)));
            end else begin
                set_req(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
            end
            tick();
            n_chk++;
            if ({resp_valid, resp_error, resp_data} !== {exp_valid, exp_error, exp_data})
                $display("FAIL random cyc=%0d got v=%b e=%b d=%h want v=%b e=%b d=%h",
                         cyc, resp_valid, resp_error, resp_data, exp_valid, exp_error, exp_data);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midflight();
        int nr, gaps, pulses, late = 0;
        set_req(1'b1, 1'b0, 16'h0001, 32'h0, 4'h0);
        tick();
        set_req(1'b1, 1'b0, 16'h0002, 32'h0, 4'h0);
        tick();
        set_req(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        reset = 1'b1;
        tick();
        n_chk++;
        if ({resp_valid, resp_error, resp_data, busy, req_ready} !== 35'h0)
            $display("FAIL midflight_outputs got v=%b e=%b d=%h busy=%b ready=%b want all 0",
                     resp_valid, resp_error, resp_data, busy, req_ready);
        else n_pass++;
        do_reset(0, nr, gaps, pulses);
        for (int i = 0; i < LAT + 3; i++) begin
            tick();
            if (resp_valid !== 1'b0) late++;
        end
        n_chk++;
        if (pulses + late != 0) $display("FAIL midflight_dropped got %0d responses want 0", pulses + late);
        else n_pass++;
    endtask

    task automatic test_clear();
        int          nr, gaps, pulses, nresp = 0;
        logic [31:0] rd = 32'h0;
        logic [31:0] want;
        set_req(1'b1, 1'b1, 16'h0005, 32'h000000FF, 4'hF);
        tick();
        set_req(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        repeat (LAT + 2) tick();
        do_reset(2, nr, gaps, pulses);
        n_chk++;
        if (nr !== EXP_NOT_READY) $display("FAIL clear_ready_delay got %0d want %0d", nr, EXP_NOT_READY);
        else n_pass++;
        n_chk++;
        if (gaps !== 0) $display("FAIL clear_busy got %0d idle cycles want 0", gaps);
        else n_pass++;
        for (int i = 0; i < LAT + 4; i++) begin
            if (i == 0) set_req(1'b1, 1'b0, 16'h0005, 32'h0, 4'h0);
            else        set_req(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
            tick();
            n_chk++;
            if ({resp_valid, resp_error, resp_data} !== {exp_valid, exp_error, exp_data})
                $display("FAIL clear_read cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, resp_valid, resp_data, exp_valid, exp_data);
            else n_pass++;
            if (resp_valid === 1'b1) begin rd = resp_data; nresp++; end
        end
`ifdef PIPELINED_MEMORY_CLEAR_EN
        want = 32'h0;
`else
        want = 32'h000000FF;
`endif
        n_chk++;
        if (nresp != 1 || rd !== want) $display("FAIL clear_contents got n=%0d d=%h want n=1 d=%h", nresp, rd, want);
        else n_pass++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        set_req(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        test_reset();
        test_basic_rw();
        test_strobe();
        test_back_to_back();
        test_out_of_range();
        test_random();
        test_reset_midflight();
        test_clear();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
